// File: rtl/ppu_bg_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : ppu_bg_fetch
//  Description : Background tile fetcher for one scanline. For each tile it
//                issues nametable, attribute, pattern-low and pattern-high
//                VRAM reads in an 8-cycle group. It feeds four 16-bit shift
//                registers that produce one palette address per cycle.
//                Optional feature macro: PPU_BG_FINE_SCROLL_EN. When defined,
//                the fine_x scroll picks the output tap. When undefined,
//                the tap is fixed at bit 15.
//  Revision    : 1.0 - initial release
// ============================================================================
module ppu_bg_fetch #(
    parameter int TILES_PER_LINE = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        render,
    input  logic [7:0]  y_idx,
    input  logic [4:0]  coarse_x,
    input  logic [2:0]  fine_x,
    input  logic [1:0]  nt_sel,
    input  logic        pt_sel,
    input  logic [7:0]  VRAM_data_in,
    output logic [15:0] VRAM_addr,
    output logic [4:0]  pixel,
    output logic        pixel_valid,
    output logic        render_ready,
    output logic        scanline_done
);

    // Two prefetch groups lead the visible tiles.
    localparam int         c_GROUPS     = TILES_PER_LINE + 2;
    localparam logic [5:0] c_LAST_GROUP = 6'(c_GROUPS - 1);
    localparam logic [5:0] c_FIRST_EMIT = 6'd2;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_FETCH = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [2:0]  r_phase;
    logic [5:0]  r_group;

    // Scanline parameters frozen at the start of FETCH.
    logic [7:0]  r_y;
    logic [4:0]  r_coarse_x;
    logic [1:0]  r_nt_sel;
    logic        r_pt_sel;

    // Per-tile fetch results.
    logic [7:0]  r_tile_idx;
    logic [1:0]  r_attr;
    logic [7:0]  r_pt_lo_byte;

    // Pixel shift registers.
    logic [15:0] r_sh_pt_lo;
    logic [15:0] r_sh_pt_hi;
    logic [15:0] r_sh_at_lo;
    logic [15:0] r_sh_at_hi;

    logic [15:0] r_vram_addr;

    logic        w_last_cycle;
    logic        w_in_emit;
    logic [5:0]  w_col_sum;
    logic [4:0]  w_col;
    logic [15:0] w_nt_base;
    logic [15:0] w_nt_addr;
    logic [15:0] w_at_addr;
    logic [15:0] w_pt_addr;
    logic [1:0]  w_attr_bits;
    logic [3:0]  w_tap;
    logic [7:0]  w_ld_pt_lo;
    logic [7:0]  w_ld_pt_hi;
    logic [7:0]  w_ld_at_lo;
    logic [7:0]  w_ld_at_hi;

`ifdef PPU_BG_FINE_SCROLL_EN
    logic [2:0]  r_fine_x;

    // Latch the fine scroll with the other scanline parameters.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fine_x <= 3'd0;
        end else if (r_state == ST_IDLE && render) begin
            r_fine_x <= fine_x;
        end
    end

    assign w_tap = 4'd15 - {1'b0, r_fine_x};
`else
    // Fine scroll is not supported in this build. The tap stays at the MSB.
    logic w_unused_fine_x;
    assign w_unused_fine_x = ^fine_x;
    assign w_tap           = 4'd15;
`endif

    assign w_last_cycle = (r_group == c_LAST_GROUP) && (r_phase == 3'd7);
    assign w_in_emit    = (r_group >= c_FIRST_EMIT);

    // State register. Reset wins over a coincident render request.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic and status outputs.
    always_comb begin
        w_state_next  = r_state;
        render_ready  = 1'b0;
        pixel_valid   = 1'b0;
        scanline_done = 1'b0;
        case (r_state)
            ST_IDLE: begin
                render_ready = 1'b1;
                if (render) begin
                    w_state_next = ST_FETCH;
                end
            end
            ST_FETCH: begin
                pixel_valid   = w_in_emit;
                scanline_done = w_last_cycle;
                if (w_last_cycle) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Phase/group counters. They sit at zero in IDLE, so every scanline
    // starts at group 0 phase 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_phase <= 3'd0;
            r_group <= 6'd0;
        end else if (r_state == ST_FETCH) begin
            r_phase <= r_phase + 3'd1;
            if (r_phase == 3'd7) begin
                r_group <= w_last_cycle ? 6'd0 : r_group + 6'd1;
            end
        end else begin
            r_phase <= 3'd0;
            r_group <= 6'd0;
        end
    end

    // Capture the scanline parameters on the IDLE->FETCH transition only.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_y        <= 8'd0;
            r_coarse_x <= 5'd0;
            r_nt_sel   <= 2'd0;
            r_pt_sel   <= 1'b0;
        end else if (r_state == ST_IDLE && render) begin
            r_y        <= y_idx;
            r_coarse_x <= coarse_x;
            r_nt_sel   <= nt_sel;
            r_pt_sel   <= pt_sel;
        end
    end

    // Address generation. Column overflow past 31 toggles the horizontal
    // nametable bit, which lets a line scroll into the adjacent nametable.
    always_comb begin
        w_col_sum = {1'b0, r_coarse_x} + r_group;
        w_col     = w_col_sum[4:0];
        w_nt_base = 16'h2000 | {4'b0000, r_nt_sel[1], r_nt_sel[0] ^ w_col_sum[5], 10'd0};
        w_nt_addr = w_nt_base + {6'd0, r_y[7:3], w_col};
        w_at_addr = w_nt_base + 16'h03C0 + {10'd0, r_y[7:5], w_col[4:2]};
        // Bit 3 selects the pattern plane: phase 4 reads low, phase 6 reads high.
        w_pt_addr = {3'b000, r_pt_sel, r_tile_idx, r_phase[1], r_y[2:0]};
    end

    // Drive a new address on even phases. Hold the last one otherwise.
    always_comb begin
        VRAM_addr = r_vram_addr;
        if (r_state == ST_FETCH) begin
            case (r_phase)
                3'd0:    VRAM_addr = w_nt_addr;
                3'd2:    VRAM_addr = w_at_addr;
                3'd4:    VRAM_addr = w_pt_addr;
                3'd6:    VRAM_addr = w_pt_addr;
                default: VRAM_addr = r_vram_addr;
            endcase
        end
    end

    // Remember the driven address so that it persists across odd phases
    // and through IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_vram_addr <= 16'd0;
        end else begin
            r_vram_addr <= VRAM_addr;
        end
    end

    // Pick the 2-bit palette of this tile's 16x16 quadrant from the
    // attribute byte.
    always_comb begin
        case ({r_y[4], w_col[1]})
            2'b11:   w_attr_bits = VRAM_data_in[7:6];
            2'b10:   w_attr_bits = VRAM_data_in[5:4];
            2'b01:   w_attr_bits = VRAM_data_in[3:2];
            default: w_attr_bits = VRAM_data_in[1:0];
        endcase
    end

    // Capture read data on odd phases. The read was issued one cycle earlier.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tile_idx   <= 8'd0;
            r_attr       <= 2'd0;
            r_pt_lo_byte <= 8'd0;
        end else if (r_state == ST_FETCH) begin
            case (r_phase)
                3'd1:    r_tile_idx   <= VRAM_data_in;
                3'd3:    r_attr       <= w_attr_bits;
                3'd5:    r_pt_lo_byte <= VRAM_data_in;
                default: ;
            endcase
        end
    end

    // Tile data for loading. The high pattern byte comes straight from the
    // bus at phase 7.
    assign w_ld_pt_lo = r_pt_lo_byte;
    assign w_ld_pt_hi = VRAM_data_in;
    assign w_ld_at_lo = {8{r_attr[0]}};
    assign w_ld_at_hi = {8{r_attr[1]}};

    // Shift registers. Groups 0 and 1 prime the upper and lower bytes.
    // From group 2 on, the registers shift every cycle and refill the lower
    // byte at the end of each group.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sh_pt_lo <= 16'd0;
            r_sh_pt_hi <= 16'd0;
            r_sh_at_lo <= 16'd0;
            r_sh_at_hi <= 16'd0;
        end else if (r_state == ST_FETCH) begin
            if (r_group == 6'd0) begin
                if (r_phase == 3'd7) begin
                    r_sh_pt_lo <= {w_ld_pt_lo, r_sh_pt_lo[7:0]};
                    r_sh_pt_hi <= {w_ld_pt_hi, r_sh_pt_hi[7:0]};
                    r_sh_at_lo <= {w_ld_at_lo, r_sh_at_lo[7:0]};
                    r_sh_at_hi <= {w_ld_at_hi, r_sh_at_hi[7:0]};
                end
            end else if (r_group == 6'd1) begin
                if (r_phase == 3'd7) begin
                    r_sh_pt_lo <= {r_sh_pt_lo[15:8], w_ld_pt_lo};
                    r_sh_pt_hi <= {r_sh_pt_hi[15:8], w_ld_pt_hi};
                    r_sh_at_lo <= {r_sh_at_lo[15:8], w_ld_at_lo};
                    r_sh_at_hi <= {r_sh_at_hi[15:8], w_ld_at_hi};
                end
            end else if (r_phase == 3'd7) begin
                r_sh_pt_lo <= {r_sh_pt_lo[14:7], w_ld_pt_lo};
                r_sh_pt_hi <= {r_sh_pt_hi[14:7], w_ld_pt_hi};
                r_sh_at_lo <= {r_sh_at_lo[14:7], w_ld_at_lo};
                r_sh_at_hi <= {r_sh_at_hi[14:7], w_ld_at_hi};
            end else begin
                r_sh_pt_lo <= {r_sh_pt_lo[14:0], 1'b0};
                r_sh_pt_hi <= {r_sh_pt_hi[14:0], 1'b0};
                r_sh_at_lo <= {r_sh_at_lo[14:0], 1'b0};
                r_sh_at_hi <= {r_sh_at_hi[14:0], 1'b0};
            end
        end
    end

    // Pixel output taps the registers before this cycle's shift.
    always_comb begin
        pixel = 5'd0;
        if (pixel_valid) begin
            pixel = {1'b0, r_sh_at_hi[w_tap], r_sh_at_lo[w_tap],
                     r_sh_pt_hi[w_tap], r_sh_pt_lo[w_tap]};
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ppu_bg_fetch.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_ppu_bg_fetch
//  Description : Directed self-checking bench for ppu_bg_fetch. It uses a
//                64 KiB VRAM model with one cycle of read latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ppu_bg_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        render;
    logic [7:0]  y_idx;
    logic [4:0]  coarse_x;
    logic [2:0]  fine_x;
    logic [1:0]  nt_sel;
    logic        pt_sel;
    logic [7:0]  VRAM_data_in;
    logic [15:0] VRAM_addr;
    logic [4:0]  pixel;
    logic        pixel_valid;
    logic        render_ready;
    logic        scanline_done;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0]  mem [0:65535];

    localparam int c_REC = 600;
    logic [15:0] rec_addr [0:c_REC-1];
    logic [4:0]  rec_pix  [0:c_REC-1];
    logic        rec_pv   [0:c_REC-1];
    logic        rec_done [0:c_REC-1];
    logic        rec_rdy  [0:c_REC-1];

`ifdef PPU_BG_FINE_SCROLL_EN
    localparam int c_ONES = 5;
`else
    localparam int c_ONES = 8;
`endif

    ppu_bg_fetch #(.TILES_PER_LINE(32)) dut (
        .clk           (clk),
        .reset         (reset),
        .render        (render),
        .y_idx         (y_idx),
        .coarse_x      (coarse_x),
        .fine_x        (fine_x),
        .nt_sel        (nt_sel),
        .pt_sel        (pt_sel),
        .VRAM_data_in  (VRAM_data_in),
        .VRAM_addr     (VRAM_addr),
        .pixel         (pixel),
        .pixel_valid   (pixel_valid),
        .render_ready  (render_ready),
        .scanline_done (scanline_done)
    );

    always #5 clk = ~clk;

    // VRAM model: the data for an address appears on the cycle after it.
    always @(posedge clk) VRAM_data_in <= mem[VRAM_addr];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    endtask

    // Sample n cycles at negedges, starting at the current negedge.
    task automatic record(input int n);
        for (int t = 0; t < n; t++) begin
            rec_addr[t] = VRAM_addr;
            rec_pix[t]  = pixel;
            rec_pv[t]   = pixel_valid;
            rec_done[t] = scanline_done;
            rec_rdy[t]  = render_ready;
            @(negedge clk);
        end
    endtask

    // Wait (bounded) for IDLE and request a line. On return the bench is at
    // the negedge of the first FETCH cycle (t = 0).
    task automatic start_line(input bit hold);
        int k;
        k = 0;
        while (!render_ready && k < 1000) begin
            @(negedge clk);
            k++;
        end
        chk("ready_before_start", {31'd0, render_ready}, 32'd1);
        render = 1'b1;
        @(negedge clk);
        if (!hold) render = 1'b0;
    endtask

    function automatic int count_pv(input int lo, input int hi);
        int c;
        c = 0;
        for (int t = lo; t <= hi; t++) if (rec_pv[t]) c++;
        return c;
    endfunction

    function automatic int count_done(input int lo, input int hi);
        int c;
        c = 0;
        for (int t = lo; t <= hi; t++) if (rec_done[t]) c++;
        return c;
    endfunction

    function automatic int first_pv(input int lo, input int hi);
        for (int t = lo; t <= hi; t++) if (rec_pv[t]) return t - lo;
        return -1;
    endfunction

    function automatic int first_done(input int lo, input int hi);
        for (int t = lo; t <= hi; t++) if (rec_done[t]) return t - lo;
        return -1;
    endfunction

    // Checks for a full default line (coarse_x=0, y=0, nt_sel=0) with 280
    // cycles recorded. Tiles 32 and 33 wrap into the nametable at 0x2400.
    task automatic check_full_line(input string pfx);
        logic [15:0] exp_nt;
        for (int g = 0; g < 34; g++) begin
            exp_nt = (g < 32) ? 16'(16'h2000 + g) : 16'(16'h2400 + g - 32);
            chk($sformatf("%s_nt_g%0d", pfx, g), {16'd0, rec_addr[8*g]}, {16'd0, exp_nt});
        end
        chk({pfx, "_at_g0"},       {16'd0, rec_addr[2]},  32'h23C0);
        chk({pfx, "_addr_hold"},   {16'd0, rec_addr[41]}, 32'h2005);
        chk({pfx, "_ready_fetch"}, {31'd0, rec_rdy[0]},   32'd0);
        chk({pfx, "_ready_after"}, {31'd0, rec_rdy[272]}, 32'd1);
        chk({pfx, "_pv_before"},   {31'd0, rec_pv[15]},   32'd0);
        chk({pfx, "_first_pv"},    first_pv(0, 279),      32'd16);
        chk({pfx, "_pv_count"},    count_pv(0, 279),      32'd256);
        chk({pfx, "_done_cycle"},  first_done(0, 279),    32'd271);
        chk({pfx, "_done_count"},  count_done(0, 279),    32'd1);
        chk({pfx, "_pv_after"},    {31'd0, rec_pv[272]},  32'd0);
    endtask

    task automatic set_line(input logic [7:0] y, input logic [4:0] cx, input logic [2:0] fx,
                            input logic [1:0] nt, input logic pt);
        y_idx = y; coarse_x = cx; fine_x = fx; nt_sel = nt; pt_sel = pt;
    endtask

    initial begin
        reset = 1'b1;
        render = 1'b0;
        set_line(8'h00, 5'd0, 3'd0, 2'd0, 1'b0);
        clear_mem();
        repeat (3) @(negedge clk);

        // Reset state.
        chk("rst_addr",  {16'd0, VRAM_addr},       32'h0);
        chk("rst_pixel", {27'd0, pixel},           32'h0);
        chk("rst_pv",    {31'd0, pixel_valid},     32'd0);
        chk("rst_done",  {31'd0, scanline_done},   32'd0);
        chk("rst_ready", {31'd0, render_ready},    32'd1);

        // A render request together with reset is ignored.
        render = 1'b1;
        @(negedge clk);
        render = 1'b0;
        reset  = 1'b0;
        @(negedge clk);
        chk("rst_render_ignored", {31'd0, render_ready}, 32'd1);

        // Scenario 1: default full scanline.
        start_line(1'b0);
        record(280);
        check_full_line("line1");

        // Scenario 2: coarse_x=30. Input changes during FETCH must not matter.
        set_line(8'h00, 5'd30, 3'd0, 2'd0, 1'b0);
        start_line(1'b0);
        set_line(8'hFF, 5'd0, 3'd0, 2'd3, 1'b1);
        record(24);
        chk("cx30_nt_g0", {16'd0, rec_addr[0]},  32'h201E);
        chk("cx30_nt_g2", {16'd0, rec_addr[16]}, 32'h2400);
        chk("cx30_at_g2", {16'd0, rec_addr[18]}, 32'h27C0);

        // Scenario 3: fine scroll. Tile 0 has pattern-low 0xFF and tile 1
        // has pattern-low 0x00.
        clear_mem();
        mem[16'h2000] = 8'h01;
        mem[16'h2001] = 8'h02;
        mem[16'h0010] = 8'hFF;
        set_line(8'h00, 5'd0, 3'd3, 2'd0, 1'b0);
        start_line(1'b0);
        record(280);
        for (int k = 0; k < 13; k++)
            chk($sformatf("fine_pix%0d", k), {27'd0, rec_pix[16+k]},
                (k < c_ONES) ? 32'h01 : 32'h00);
        chk("fine_first_pv", first_pv(0, 279), 32'd16);
        chk("fine_pv_count", count_pv(0, 279), 32'd256);

        // Scenario 4: attribute quadrants and pattern addresses at y=0x13.
        // The AT byte 0xE4 covers columns 0..3. Columns 0 and 1 have quadrant
        // {y[4],col[1]}=10 (bits 5:4 = 2'b10). Column 2 has quadrant 11
        // (bits 7:6 = 2'b11).
        clear_mem();
        mem[16'h2042] = 8'h25;
        mem[16'h23C0] = 8'hE4;
        mem[16'h1253] = 8'h80;
        mem[16'h125B] = 8'h80;
        set_line(8'h13, 5'd0, 3'd0, 2'd0, 1'b1);
        start_line(1'b0);
        record(40);
        chk("attr_nt_g2",   {16'd0, rec_addr[16]}, 32'h2042);
        chk("attr_at_g2",   {16'd0, rec_addr[18]}, 32'h23C0);
        chk("attr_ptlo_g2", {16'd0, rec_addr[20]}, 32'h1253);
        chk("attr_pthi_g2", {16'd0, rec_addr[22]}, 32'h125B);
        chk("attr_pix_t0",  {27'd0, rec_pix[16]},  32'h08);
        chk("attr_pix_t1",  {27'd0, rec_pix[24]},  32'h08);
        chk("attr_pix_t2",  {27'd0, rec_pix[32]},  32'h0F);
        chk("attr_pix_t2b", {27'd0, rec_pix[33]},  32'h0C);

        // Scenario 5: reset at group 5 phase 3, then a clean line.
        clear_mem();
        set_line(8'h00, 5'd0, 3'd0, 2'd0, 1'b0);
        start_line(1'b0);
        record(43);
        chk("mid_pre_addr", {16'd0, VRAM_addr}, 32'h23C1);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_addr",  {16'd0, VRAM_addr},     32'h0);
        chk("mid_rst_pixel", {27'd0, pixel},         32'h0);
        chk("mid_rst_pv",    {31'd0, pixel_valid},   32'd0);
        chk("mid_rst_done",  {31'd0, scanline_done}, 32'd0);
        chk("mid_rst_ready", {31'd0, render_ready},  32'd1);
        reset = 1'b0;
        @(negedge clk);
        start_line(1'b0);
        record(280);
        check_full_line("line5");

        // Scenario 6: render held high gives back-to-back lines with one
        // IDLE cycle between them.
        start_line(1'b1);
        record(560);
        render = 1'b0;
        chk("b2b_done1",      {31'd0, rec_done[271]}, 32'd1);
        chk("b2b_idle",       {31'd0, rec_rdy[272]},  32'd1);
        chk("b2b_restart",    {31'd0, rec_rdy[273]},  32'd0);
        chk("b2b_nt_g0",      {16'd0, rec_addr[273]}, 32'h2000);
        chk("b2b_first_pv2",  first_pv(273, 559),     32'd16);
        chk("b2b_done2",      {31'd0, rec_done[544]}, 32'd1);
        chk("b2b_done_count", count_done(0, 559),     32'd2);
        chk("b2b_pv_count",   count_pv(0, 559),       32'd512);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
